// File: rtl/iic_responder_if.sv
// Application-side bundle of the IIC responder: measurement
// bytes in, received command and status pulses out.
interface iic_responder_if;
   logic [7:0] meas_ms;
   logic [7:0] meas_ls;
   logic [7:0] cmd_byte;
   logic       cmd_valid;
   logic       rd_done;
   logic       busy;

   modport slave (
      input  meas_ms,
      input  meas_ls,
      output cmd_byte,
      output cmd_valid,
      output rd_done,
      output busy
   );

   modport master (
      output meas_ms,
      output meas_ls,
      input  cmd_byte,
      input  cmd_valid,
      input  rd_done,
      input  busy
   );
endinterface

// File: rtl/iic_responder.sv
// IIC target: accepts one command byte on write, returns a
// two-byte measurement on read. Oversamples scl/sda with clk.
module iic_responder #(
   parameter logic [6:0] SLAVE_ADDR  = 7'h40,
   parameter int         SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl,
   inout  wire  sda,
   iic_responder_if.slave app
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK,
      TX_MS, MACK1, TX_LS, MACK2, WAIT_STOP
   } state_t;

   state_t      state;
   logic [SYNC_STAGES:0] scl_sh;
   logic [SYNC_STAGES:0] sda_sh;
   logic        sda_drv_low;
   logic        busy_q;
   logic        cmd_valid_q;
   logic        rd_done_q;
   logic [7:0]  cmd_q;
   logic [15:0] shadow;
   logic [3:0]  bit_cnt;
   logic [6:0]  shreg;
   logic        rw;

   logic scl_s, scl_q, sda_s, sda_q;
   logic scl_rise, scl_fall, sda_rise, sda_fall;
   logic start, stop;
   logic [7:0] rx_byte;

   assign sda = sda_drv_low ? 1'b0 : 1'bz;

   assign app.cmd_byte  = cmd_q;
   assign app.cmd_valid = cmd_valid_q;
   assign app.rd_done   = rd_done_q;
   assign app.busy      = busy_q;

   // top bit of each chain is the previous synced sample
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sh <= '1;
         sda_sh <= '1;
      end else begin
         scl_sh <= {scl_sh[SYNC_STAGES-1:0], scl};
         sda_sh <= {sda_sh[SYNC_STAGES-1:0], sda};
      end
   end

   assign scl_s    = scl_sh[SYNC_STAGES-1];
   assign scl_q    = scl_sh[SYNC_STAGES];
   assign sda_s    = sda_sh[SYNC_STAGES-1];
   assign sda_q    = sda_sh[SYNC_STAGES];
   assign scl_rise = scl_s & ~scl_q;
   assign scl_fall = ~scl_s & scl_q;
   assign sda_rise = sda_s & ~sda_q;
   assign sda_fall = ~sda_s & sda_q;
   assign start    = sda_fall & scl_s;
   assign stop     = sda_rise & scl_s;
   assign rx_byte  = {shreg, sda_s};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         sda_drv_low <= 1'b0;
         busy_q      <= 1'b0;
         cmd_valid_q <= 1'b0;
         rd_done_q   <= 1'b0;
         cmd_q       <= 8'h00;
         shadow      <= 16'h0000;
         bit_cnt     <= 4'd0;
         shreg       <= 7'h00;
         rw          <= 1'b0;
      end else begin
         cmd_valid_q <= 1'b0;
         rd_done_q   <= 1'b0;
         if (start) begin
            state       <= ADDR;
            bit_cnt     <= 4'd0;
            sda_drv_low <= 1'b0;
            busy_q      <= 1'b1;
         end else if (stop) begin
            state       <= IDLE;
            bit_cnt     <= 4'd0;
            sda_drv_low <= 1'b0;
            busy_q      <= 1'b0;
         end else begin
            case (state)
               ADDR: if (scl_rise) begin
                  shreg <= rx_byte[6:0];
                  if (bit_cnt == 4'd7) begin
                     bit_cnt <= 4'd0;
                     if (rx_byte[7:1] == SLAVE_ADDR) begin
                        rw    <= rx_byte[0];
                        state <= ADDR_ACK;
                        if (rx_byte[0])
                           shadow <= {app.meas_ms, app.meas_ls};
                     end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
               // drv low marks the second half of the ack slot
               ADDR_ACK: if (scl_fall) begin
                  if (!sda_drv_low) begin
                     sda_drv_low <= 1'b1;
                  end else if (rw) begin
                     state       <= TX_MS;
                     sda_drv_low <= ~shadow[15];
                     shadow      <= {shadow[14:0], 1'b0};
                     bit_cnt     <= 4'd1;
                  end else begin
                     state       <= CMD;
                     sda_drv_low <= 1'b0;
                  end
               end
               CMD: if (scl_rise) begin
                  shreg <= rx_byte[6:0];
                  if (bit_cnt == 4'd7) begin
                     bit_cnt     <= 4'd0;
                     cmd_q       <= rx_byte;
                     cmd_valid_q <= 1'b1;
                     state       <= CMD_ACK;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
               CMD_ACK: if (scl_fall) begin
                  if (!sda_drv_low) begin
                     sda_drv_low <= 1'b1;
                  end else begin
                     sda_drv_low <= 1'b0;
                     state       <= WAIT_STOP;
                  end
               end
               TX_MS, TX_LS: if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     sda_drv_low <= 1'b0;
                     bit_cnt     <= 4'd0;
                     state       <= (state == TX_MS) ? MACK1 : MACK2;
                  end else begin
                     sda_drv_low <= ~shadow[15];
                     shadow      <= {shadow[14:0], 1'b0};
                     bit_cnt     <= bit_cnt + 4'd1;
                  end
               end
               MACK1: if (scl_rise) begin
                  state <= sda_s ? WAIT_STOP : TX_LS;
               end
               MACK2: if (scl_rise) begin
                  state     <= WAIT_STOP;
                  rd_done_q <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/iic_responder.md
IIC_RESPONDER -- requirements
Module: iic_responder

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h40, 7-bit target address matched in write and read address phases.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops on scl and sda (min 2).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge; one clock only.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port scl  input  1  IIC clock from master; responder never drives or stretches scl.
REQ-006 SHALL have port sda  inout  1  IIC data, open-drain: driven 0 when sda_drv_low=1, else high-Z.
REQ-007 SHALL have port meas_ms  input  8  MSB data byte returned on read.
REQ-008 SHALL have port meas_ls  input  8  LSB data byte returned on read.
REQ-009 SHALL have port cmd_byte  output  8  last command byte received after a matched write address.
REQ-010 SHALL have port cmd_valid  output  1  one-clk pulse when cmd_byte updates.
REQ-011 SHALL have port rd_done  output  1  one-clk pulse when the LS byte has been shifted out and its ack slot sampled.
REQ-012 SHALL have port busy  output  1  high from START until STOP or address mismatch.

Function
REQ-013 SHALL synchronize scl/sda through SYNC_STAGES flops; scl_rise/scl_fall/sda_rise/sda_fall derived from last two synchronized samples.
REQ-014 SHALL detect START as sda_fall while synced scl=1 and STOP as sda_rise while synced scl=1; both take priority over all state transitions.
REQ-015 SHALL on START from any state (incl. repeated START) enter ADDR with bit counter cleared and sda released.
REQ-016 SHALL on STOP from any state enter IDLE, release sda, deassert busy.
REQ-017 SHALL use states IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, TX_MS, MACK1, TX_LS, MACK2, WAIT_STOP.
REQ-018 SHALL sample sda on each scl_rise in ADDR/CMD, MSB first, 8 bits; bit 0 of address byte is R/W (1=read).
REQ-019 SHALL on 8th address bit: address match -> ADDR_ACK; mismatch -> IDLE, sda untouched, busy=0.
REQ-020 SHALL in ADDR_ACK/CMD_ACK drive sda low from the scl_fall after bit 8 until the scl_fall after the 9th clock, then release (unless transmitting).
REQ-021 SHALL after ADDR_ACK go to CMD if R/W=0, TX_MS if R/W=1; meas_ms/meas_ls latched into a shadow register at the 8th address bit of a matched read.
REQ-022 SHALL always ACK the command byte; cmd_byte updates and cmd_valid pulses on the 8th command bit's scl_rise; then CMD_ACK -> WAIT_STOP awaiting STOP or repeated START; further write bytes are not ACKed.
REQ-023 SHALL in TX_MS/TX_LS place each bit on sda (drive low for 0, release for 1) on scl_fall, MSB first, first bit on the ACK-ending scl_fall; hold stable while scl high.
REQ-024 SHALL release sda on the scl_fall after the 8th data bit and sample master ack on next scl_rise: MACK1 ack(0) -> TX_LS, nack(1) -> WAIT_STOP; MACK2 any value -> WAIT_STOP with rd_done pulse.
REQ-025 SHALL, if STOP/START interrupts a byte, discard partial data: no cmd_valid, no rd_done.
REQ-026 SHALL ignore scl/sda activity in IDLE and WAIT_STOP except START/STOP detection.
REQ-027 SHALL never drive sda high; meas_* changes after shadow latch do not affect an in-flight read.

Reset
REQ-028 SHALL on rst=1 asynchronously go IDLE, release sda, clear cmd_byte=8'h00, cmd_valid=0, rd_done=0, busy=0, shadow and bit counter=0.
REQ-029 SHALL after rst mid-transaction ignore the bus until the next START.

Verification
REQ-030 Write frame START, 0x80, 0xE3, STOP -> ACK on both bytes, cmd_byte=8'hE3, one cmd_valid pulse, busy low after STOP.
REQ-031 START,0x80,0xE3, repeated START,0x81, master ACK after MS, ACK after LS, STOP, meas_ms=8'h66 meas_ls=8'h5C -> bytes 0x66,0x5C on sda, one rd_done pulse.
REQ-032 START, 0x90 (wrong address), 0xE3, STOP -> sda never driven low, no cmd_valid, busy=0 after 8th bit.
REQ-033 Read with master NACK after MS byte -> LS not sent, sda released, no rd_done, STOP returns IDLE.
REQ-034 STOP after 4 command bits, and separately rst pulsed during TX_MS -> sda released immediately/on STOP, no pulses, next full frame works normally.
REQ-035 meas_ms changed from 8'h66 to 8'hFF during TX_MS -> bus still carries 0x66.
